// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes, legality check and default widths.
// Imported by the ALU and by the ID/EX stage so both agree on the encoding.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  function automatic logic is_legal_op(input logic [3:0] code);
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: is_legal_op = 1'b1;
      default:                                            is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/forward_mux.sv
// Resolves one source operand against the EX/MEM and MEM/WB writeback ports.
// EX/MEM is younger and wins; register 0 is never forwarded.
module forward_mux
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] idx_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic idx_nonzero;
  assign idx_nonzero = (idx_i != '0);

  always_comb begin
    // NOTE: default assignment first so every path drives data_o; no latch.
    data_o = rf_data_i;
    if (idx_nonzero && exmem_regwrite_i && (exmem_rd_i == idx_i)) begin
      data_o = exmem_result_i;
    end else if (idx_nonzero && memwb_regwrite_i && (memwb_rd_i == idx_i)) begin
      data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards operands, applies ALUSrc, and presents
// registered A/B/ALUControl to the ALU behind a valid/ready handshake.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm,
  input  logic              in_alusrc,
  input  logic [3:0]        in_aluctrl,
  input  logic              in_regwrite,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [3:0]        out_aluctrl,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_regwrite,
  output logic              out_illegal
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   a_q, b_q, a_d, b_d;
  logic [3:0]          ctrl_q, ctrl_d;
  logic [REG_AW-1:0]   rd_q;
  logic                rw_q, rw_d, ill_q, legal;
  logic [DATA_W-1:0]   rs_fwd, rt_fwd, imm_ext;
  logic                capture;

  forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .idx_i(in_rs), .rf_data_i(in_rs_data),
    .exmem_regwrite_i(exmem_regwrite), .exmem_rd_i(exmem_rd), .exmem_result_i(exmem_result),
    .memwb_regwrite_i(memwb_regwrite), .memwb_rd_i(memwb_rd), .memwb_data_i(memwb_data),
    .data_o(rs_fwd)
  );

  forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .idx_i(in_rt), .rf_data_i(in_rt_data),
    .exmem_regwrite_i(exmem_regwrite), .exmem_rd_i(exmem_rd), .exmem_result_i(exmem_result),
    .memwb_regwrite_i(memwb_regwrite), .memwb_rd_i(memwb_rd), .memwb_data_i(memwb_data),
    .data_o(rt_fwd)
  );

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign capture   = in_valid && in_ready;

  assign imm_ext = {{(DATA_W-16){in_imm[15]}}, in_imm};
  assign legal   = is_legal_op(in_aluctrl);
  assign a_d     = rs_fwd;
  assign b_d     = in_alusrc ? imm_ext : rt_fwd;
  // Unsupported codes are downgraded to a harmless ADD that never writes back.
  assign ctrl_d  = legal ? in_aluctrl : 4'(ALU_ADD);
  assign rw_d    = in_regwrite && legal;

  // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else if (capture) begin
      state_q <= ST_FULL;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= in_rd;
      rw_q    <= rw_d;
      ill_q   <= !legal;
    end else if (in_ready) begin
      state_q <= ST_EMPTY;
    end
  end

  assign out_a        = a_q;
  assign out_b        = b_q;
  assign out_aluctrl  = ctrl_q;
  assign out_rd       = rd_q;
  assign out_illegal  = ill_q;
  assign out_regwrite = out_valid && rw_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, stall/flush/reset
// sequences, then random traffic against a transaction-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_rs_data, in_rt_data;
  logic [15:0] in_imm;
  logic        in_alusrc;
  logic [3:0]  in_aluctrl;
  logic        in_regwrite;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_aluctrl;
  logic [4:0]  out_rd;
  logic        out_regwrite, out_illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_alusrc(in_alusrc), .in_aluctrl(in_aluctrl), .in_regwrite(in_regwrite),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_aluctrl(out_aluctrl), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic        alusrc;
    logic [3:0]  ctrl;
    logic        rw;
    logic        ex_rw;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] e_a, e_b;
    logic [3:0]  e_ctrl;
    logic        e_ill, e_rw;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
    in_rs_data = v.rs_data; in_rt_data = v.rt_data;
    in_imm = v.imm; in_alusrc = v.alusrc; in_aluctrl = v.ctrl; in_regwrite = v.rw;
    exmem_regwrite = v.ex_rw; exmem_rd = v.ex_rd; exmem_result = v.ex_res;
    memwb_regwrite = v.wb_rw; memwb_rd = v.wb_rd; memwb_data = v.wb_data;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " a"}, out_a, v.e_a);
    check({tag, " b"}, out_b, v.e_b);
    check({tag, " ctrl"}, 32'(out_aluctrl), 32'(v.e_ctrl));
    check({tag, " rd"}, 32'(out_rd), 32'(v.rd));
    check({tag, " illegal"}, 32'(out_illegal), 32'(v.e_ill));
    check({tag, " regwrite"}, 32'(out_regwrite), 32'(v.e_rw));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid"}, 32'(out_valid), 32'd0);
    check({tag, " a"}, out_a, 32'd0);
    check({tag, " b"}, out_b, 32'd0);
    check({tag, " ctrl"}, 32'(out_aluctrl), 32'd0);
    check({tag, " rd"}, 32'(out_rd), 32'd0);
    check({tag, " regwrite"}, 32'(out_regwrite), 32'd0);
    check({tag, " illegal"}, 32'(out_illegal), 32'd0);
  endtask

  // Reference model: operand value seen by the instruction under the hazard rules.
  function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return rf;
    if (exmem_regwrite && exmem_rd == idx) return exmem_result;
    if (memwb_regwrite && memwb_rd == idx) return memwb_data;
    return rf;
  endfunction

  function automatic bit ref_legal(input logic [3:0] c);
    return c inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
  endfunction

  logic [3:0] legal_ops [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

  vec_t v_basic, v_x, v_y;
  bit          m_valid;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_ctrl;
  logic [4:0]  m_rd;
  logic        m_rw, m_ill;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    v_basic = '{5'd3, 5'd4, 5'd9, 32'h10, 32'h20, 16'h0, 1'b0, 4'b0010, 1'b1,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h10, 32'h20, 4'b0010, 1'b0, 1'b1};
    drive_vec(v_basic);

    vecs.push_back(v_basic);
    // EX/MEM beats MEM/WB on the same index
    vecs.push_back('{5'd5, 5'd6, 5'd1, 32'h55, 32'h66, 16'h0, 1'b0, 4'b0110, 1'b1,
                     1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hAAAA, 32'h66, 4'b0110, 1'b0, 1'b1});
    vecs.push_back('{5'd5, 5'd6, 5'd1, 32'h55, 32'h66, 16'h0, 1'b0, 4'b0110, 1'b1,
                     1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hBBBB, 32'h66, 4'b0110, 1'b0, 1'b1});
    // register 0 never forwarded
    vecs.push_back('{5'd0, 5'd0, 5'd2, 32'h0, 32'h0, 16'h0, 1'b0, 4'b0000, 1'b1,
                     1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{5'd1, 5'd2, 5'd3, 32'h7, 32'h8, 16'hFFFC, 1'b1, 4'b0010, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h7, 32'hFFFFFFFC, 4'b0010, 1'b0, 1'b1});
    vecs.push_back('{5'd1, 5'd2, 5'd3, 32'h7, 32'h8, 16'h7FFF, 1'b1, 4'b0111, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h7, 32'h00007FFF, 4'b0111, 1'b0, 1'b1});
    vecs.push_back('{5'd1, 5'd2, 5'd4, 32'h1, 32'h2, 16'h0, 1'b0, 4'b1111, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h1, 32'h2, 4'b0010, 1'b1, 1'b0});
    vecs.push_back('{5'd8, 5'd7, 5'd5, 32'h80, 32'h70, 16'h0, 1'b0, 4'b0001, 1'b1,
                     1'b1, 5'd8, 32'hE8, 1'b1, 5'd7, 32'hD7, 32'hE8, 32'hD7, 4'b0001, 1'b0, 1'b1});
    vecs.push_back('{5'd9, 5'd7, 5'd6, 32'h90, 32'h70, 16'h0004, 1'b1, 4'b1100, 1'b1,
                     1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hD7, 32'h90, 32'h4, 4'b1100, 1'b0, 1'b1});
    vecs.push_back('{5'd10, 5'd11, 5'd7, 32'hA0, 32'hB0, 16'h0, 1'b0, 4'b0000, 1'b0,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hA0, 32'hB0, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{5'd10, 5'd11, 5'd8, 32'hA0, 32'hB0, 16'h0, 1'b0, 4'b0011, 1'b0,
                     1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hA0, 32'hB0, 4'b0010, 1'b1, 1'b0});
    vecs.push_back('{5'd12, 5'd13, 5'd9, 32'hC0, 32'hD0, 16'h0, 1'b0, 4'b0110, 1'b1,
                     1'b0, 5'd12, 32'hEE, 1'b0, 5'd13, 32'hFF, 32'hC0, 32'hD0, 4'b0110, 1'b0, 1'b1});

    #2;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 check("ready after reset", 32'(in_ready), 32'd1);

    // Directed table, back-to-back at full throughput
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive_vec(vecs[i]);
      @(posedge clk); #1;
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Stall: hold X for 3 cycles while Y is offered, then Y appears
    v_x = vecs[0];
    v_y = vecs[4];
    drive_vec(v_x);
    @(posedge clk); #1;
    check_vec("stall capture", v_x);
    drive_vec(v_y); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("stall%0d ready", c), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check_vec($sformatf("stall%0d hold", c), v_x);
    end
    out_ready = 1'b1;
    #1 check("stall release ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check_vec("stall release", v_y);

    // Flush beats a simultaneous capture
    drive_vec(vecs[1]); flush = 1'b1;
    @(posedge clk); #1;
    check("flush valid", 32'(out_valid), 32'd0);
    check("flush regwrite", 32'(out_regwrite), 32'd0);
    flush = 1'b0;
    @(posedge clk); #1;
    check_vec("after flush", vecs[1]);

    // Reset mid-stream while FULL
    drive_vec(vecs[7]);
    @(posedge clk); #2;
    reset = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1 check("midreset ready", 32'(in_ready), 32'd1);
    drive_vec(v_basic); in_valid = 1'b1;
    @(posedge clk); #1;
    check_vec("post-reset basic", v_basic);

    // Random traffic against the transaction model
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    m_valid = 1'b0;
    m_a = '0; m_b = '0; m_ctrl = '0; m_rd = '0; m_rw = 1'b0; m_ill = 1'b0;
    for (int n = 0; n < 400; n++) begin
      bit nv; bit rdy;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      in_rs = 5'($urandom_range(0, 3)); in_rt = 5'($urandom_range(0, 3));
      in_rd = 5'($urandom);
      in_rs_data = (in_rs == 0) ? 32'd0 : $urandom;
      in_rt_data = (in_rt == 0) ? 32'd0 : $urandom;
      in_imm = 16'($urandom); in_alusrc = 1'($urandom);
      in_aluctrl = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 5)];
      in_regwrite = 1'($urandom);
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_data = $urandom;
      #1;
      rdy = !m_valid || out_ready;
      check("rand in_ready", 32'(in_ready), 32'(rdy));
      nv = m_valid;
      if (flush) nv = 1'b0;
      else if (in_valid && rdy) begin
        nv = 1'b1;
        m_a = ref_operand(in_rs, in_rs_data);
        m_b = in_alusrc ? 32'(signed'(in_imm)) : ref_operand(in_rt, in_rt_data);
        m_ill = !ref_legal(in_aluctrl);
        m_ctrl = m_ill ? 4'b0010 : in_aluctrl;
        m_rd = in_rd;
        m_rw = in_regwrite && !m_ill;
      end else if (rdy) nv = 1'b0;
      m_valid = nv;
      @(posedge clk); #1;
      check("rand valid", 32'(out_valid), 32'(m_valid));
      check("rand regwrite", 32'(out_regwrite), 32'(m_valid && m_rw));
      if (m_valid) begin
        check("rand a", out_a, m_a);
        check("rand b", out_b, m_b);
        check("rand ctrl", 32'(out_aluctrl), 32'(m_ctrl));
        check("rand rd", 32'(out_rd), 32'(m_rd));
        check("rand illegal", 32'(out_illegal), 32'(m_ill));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
